// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit.
// Macros: PC_RESET_VAL (reset fetch address, defaults to 0).
`ifndef PC_RESET_VAL
`define PC_RESET_VAL 32'h0000_0000
`endif

package ifetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally from storage.
module ifetch_fifo #(
  parameter int unsigned Depth    = 2,
  parameter type         entry_t  = logic [31:0],
  parameter entry_t      ResetVal = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     data_i,
  input  logic                       pop_i,
  output entry_t                     data_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, full, push_en, pop_en;

  // Next-state: flush wins over push/pop; a pop frees the slot for a push when full.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CntW'(Depth));
    pop_en   = pop_i && !empty;
    push_en  = push_i && (!full || pop_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push_en && !pop_en) begin
        count_d = count_q + CntW'(1);
      end else if (pop_en && !push_en) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= ResetVal;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: credit-limited requests to imem, in-order response buffering,
// redirect flush with discard of in-flight responses.
// Macros: IFETCH_ALIGN_CHECK_EN adds fetch_misalign_o and blocks misaligned fetches.
`ifndef PC_RESET_VAL
`define PC_RESET_VAL 32'h0000_0000
`endif

module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pc_i,
  input  logic        load_arith_i,
  output logic        incr_pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        dec_ready_i
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam fetch_entry_t IbufReset = '{addr: `PC_RESET_VAL, instr: 32'h0};

  logic [CntW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
  logic [CntW-1:0] ibuf_count, aq_count;
  ifetch_state_e   state_q, state_d;
  logic            credit_ok, misalign, accept, rsp_live, ibuf_push, ibuf_pop;
  fetch_entry_t    ibuf_head, ibuf_wdata;
  logic [31:0]     aq_head;

  // Request issue, response routing and counter next-state.
  always_comb begin
`ifdef IFETCH_ALIGN_CHECK_EN
    misalign = (pc_i[$clog2(INSTR_BYTES)-1:0] != '0) && !load_arith_i;
`else
    misalign = 1'b0;
`endif
    // Outstanding plus buffered never exceeds depth, so every grant has a slot.
    credit_ok   = ({1'b0, outstanding_q} + {1'b0, ibuf_count}) < SumW'(FIFO_DEPTH);
    imem_req_o  = rst_n_i && !load_arith_i && !misalign && credit_ok;
    imem_addr_o = pc_i;
    accept      = imem_req_o && imem_gnt_i;
    incr_pc_o   = accept;

    rsp_live   = imem_rvalid_i && (state_q == RUN);
    ibuf_push  = rsp_live;
    ibuf_wdata = '{addr: aq_head, instr: imem_rdata_i};
    ibuf_pop   = instr_valid_o && dec_ready_i;

    outstanding_d = outstanding_q;
    unique case ({accept, imem_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    drop_d = drop_q;
    if (load_arith_i) begin
      // outstanding_q already includes responses owed to an earlier redirect, so this is
      // the old drop count plus the live in-flight requests, minus any returning now.
      drop_d = outstanding_q - CntW'(imem_rvalid_i);
    end else if (imem_rvalid_i && (state_q == DRAIN)) begin
      drop_d = drop_q - CntW'(1);
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;

    instr_valid_o = (ibuf_count != '0);
    instr_o       = ibuf_head.instr;
    instr_pc_o    = ibuf_head.addr;
`ifdef IFETCH_ALIGN_CHECK_EN
    // Older instructions drain before the fault is reported.
    fetch_misalign_o = misalign && (outstanding_q == '0) && (ibuf_count == '0);
`endif
  end

  // Counter and drain-state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      outstanding_q <= '0;
      drop_q        <= '0;
      state_q       <= RUN;
    end else begin
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      state_q       <= state_d;
    end
  end

  // Addresses of every in-flight request, dropped or not, in issue order.
  ifetch_fifo #(
    .Depth    (FIFO_DEPTH),
    .entry_t  (logic [31:0]),
    .ResetVal (32'h0)
  ) u_addr_q (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (1'b0),
    .push_i  (accept),
    .data_i  (pc_i),
    .pop_i   (imem_rvalid_i),
    .data_o  (aq_head),
    .count_o (aq_count)
  );

  // Instruction buffer towards decode.
  ifetch_fifo #(
    .Depth    (FIFO_DEPTH),
    .entry_t  (fetch_entry_t),
    .ResetVal (IbufReset)
  ) u_ibuf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (load_arith_i),
    .push_i  (ibuf_push),
    .data_i  (ibuf_wdata),
    .pop_i   (ibuf_pop),
    .data_o  (ibuf_head),
    .count_o (ibuf_count)
  );

  rvalid_needs_request: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) imem_rvalid_i |-> (outstanding_q != '0));

  addr_q_tracks_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) (aq_count == outstanding_q) && (drop_q <= outstanding_q));

endmodule

// File: tb/tb_ifetch.sv
// Directed table-driven bench for ifetch (FIFO_DEPTH=2).
`ifndef PC_RESET_VAL
`define PC_RESET_VAL 32'h0000_0000
`endif

module tb_ifetch;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] pc_i;
  logic        load_arith_i;
  logic        incr_pc_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        dec_ready_i;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_misalign_o;
`endif

  always #5 clk_i = ~clk_i;

  ifetch #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pc_i          (pc_i),
    .load_arith_i  (load_arith_i),
    .incr_pc_o     (incr_pc_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .dec_ready_i   (dec_ready_i)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  typedef struct {
    logic        load;
    logic [31:0] target;
    logic        gnt;
    logic        rv;
    logic        dr;
    logic        e_req;
    logic        e_incr;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic        e_mis;
  } row_t;

  row_t        rows[$];
  row_t        mrows[$];
  logic [31:0] memq[$];
  logic [31:0] pc_model;
  int          checks = 0;
  int          errors = 0;

  function automatic row_t mk(input logic load, input logic [31:0] target, input logic gnt,
                              input logic rv, input logic dr, input logic e_req,
                              input logic e_incr, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_ipc,
                              input logic e_mis);
    row_t r;
    r = '{load, target, gnt, rv, dr, e_req, e_incr, e_addr, e_valid, e_ipc, e_mis};
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of a row at negedge, check #1 later, update memory/PC models at posedge.
  task automatic apply(input row_t r, input string tag);
    logic acc;
    @(negedge clk_i);
    load_arith_i  = r.load;
    pc_i          = pc_model;
    imem_gnt_i    = r.gnt;
    dec_ready_i   = r.dr;
    imem_rvalid_i = r.rv;
    imem_rdata_i  = 32'h0;
    if (r.rv) begin
      if (memq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.rsp: got no pending request, want one", tag);
      end else begin
        imem_rdata_i = mem_word(memq[0]);
      end
    end
    #1;
    chk({tag, ".req"}, imem_req_o, r.e_req);
    chk({tag, ".incr"}, incr_pc_o, r.e_incr);
    chk({tag, ".valid"}, instr_valid_o, r.e_valid);
    if (r.e_req) chk({tag, ".addr"}, imem_addr_o, r.e_addr);
    if (r.e_valid) begin
      chk({tag, ".ipc"}, instr_pc_o, r.e_ipc);
      chk({tag, ".instr"}, instr_o, mem_word(r.e_ipc));
    end
`ifdef IFETCH_ALIGN_CHECK_EN
    chk({tag, ".mis"}, fetch_misalign_o, r.e_mis);
`endif
    acc = imem_req_o && imem_gnt_i;
    @(posedge clk_i);
    if (r.rv && memq.size() > 0) void'(memq.pop_front());
    if (acc) memq.push_back(pc_i);
    if (r.load) pc_model = r.target;
    else if (acc) pc_model = pc_model + 32'd4;
  endtask

  // Credit bound: in-flight never exceeds depth and drops never exceed in-flight.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1) begin
      checks++;
      if (dut.outstanding_q > 2'd2 || dut.drop_q > dut.outstanding_q) begin
        errors++;
        $display("FAIL credit_bound: got out=%0d drop=%0d, want out<=2 drop<=out",
                 dut.outstanding_q, dut.drop_q);
      end
    end
  end

  initial begin
    rst_n_i       = 1'b0;
    load_arith_i  = 1'b0;
    pc_i          = `PC_RESET_VAL;
    pc_model      = `PC_RESET_VAL;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    dec_ready_i   = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset.req", imem_req_o, 1'b0);
    chk("reset.incr", incr_pc_o, 1'b0);
    chk("reset.valid", instr_valid_o, 1'b0);
    chk("reset.instr", instr_o, 32'h0);
    chk("reset.ipc", instr_pc_o, `PC_RESET_VAL);
    imem_gnt_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;

    //                 load target   gnt rv dr  req inc addr       vld ipc        mis
    // streaming with dec_ready=1
    rows.push_back(mk(0, 32'h0,   1, 0, 1, 1, 1, 32'h00,  0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 1, 1, 32'h04,  0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 0, 0, 32'h0,   1, 32'h00, 0));
    rows.push_back(mk(0, 32'h0,   1, 0, 1, 1, 1, 32'h08,  1, 32'h04, 0));
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 1, 1, 32'h0C,  0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 0, 0, 32'h0,   1, 32'h08, 0));
    // decode stalled: credits run out, one pop frees exactly one request
    rows.push_back(mk(0, 32'h0,   1, 0, 0, 1, 1, 32'h10,  1, 32'h0C, 0));
    rows.push_back(mk(0, 32'h0,   1, 1, 0, 0, 0, 32'h0,   1, 32'h0C, 0));
    rows.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   1, 32'h0C, 0));
    rows.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   1, 32'h0C, 0));
    rows.push_back(mk(0, 32'h0,   1, 0, 0, 1, 1, 32'h14,  1, 32'h10, 0));
    rows.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   1, 32'h10, 0));
    // rvalid + pop together at the credit limit
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 0, 0, 32'h0,   1, 32'h10, 0));
    // grant delayed 3 cycles: request and address held
    rows.push_back(mk(0, 32'h0,   0, 0, 1, 1, 0, 32'h18,  1, 32'h14, 0));
    rows.push_back(mk(0, 32'h0,   0, 0, 1, 1, 0, 32'h18,  0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   0, 0, 1, 1, 0, 32'h18,  0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 0, 1, 1, 1, 32'h18,  0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 0, 1, 1, 1, 32'h1C,  0, 32'h0,  0));
    // redirect with 2 in flight: both responses dropped, 0x100 delivered first
    rows.push_back(mk(1, 32'h100, 1, 0, 1, 0, 0, 32'h0,   0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 0, 0, 32'h0,   0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   1, 1, 1, 1, 1, 32'h100, 0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   0, 1, 0, 1, 0, 32'h104, 0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   0, 0, 0, 1, 0, 32'h104, 1, 32'h100, 0));
    // redirect with a buffered entry and dec_ready: flush wins
    rows.push_back(mk(1, 32'h200, 1, 0, 1, 0, 0, 32'h0,   1, 32'h100, 0));
    rows.push_back(mk(0, 32'h0,   0, 0, 1, 1, 0, 32'h200, 0, 32'h0,  0));
    // redirect in the same cycle as a live response: response discarded
    rows.push_back(mk(0, 32'h0,   1, 0, 1, 1, 1, 32'h200, 0, 32'h0,  0));
    rows.push_back(mk(1, 32'h300, 1, 1, 0, 0, 0, 32'h0,   0, 32'h0,  0));
    rows.push_back(mk(0, 32'h0,   0, 0, 0, 1, 0, 32'h300, 0, 32'h0,  0));

    foreach (rows[i]) apply(rows[i], $sformatf("row%0d", i));

`ifdef IFETCH_ALIGN_CHECK_EN
    // misaligned target blocks issue and flags once drained; redirect clears it
    mrows.push_back(mk(1, 32'h102, 1, 0, 1, 0, 0, 32'h0,   0, 32'h0, 0));
    mrows.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   0, 32'h0, 1));
    mrows.push_back(mk(0, 32'h0,   1, 0, 1, 0, 0, 32'h0,   0, 32'h0, 1));
    mrows.push_back(mk(1, 32'h200, 1, 0, 1, 0, 0, 32'h0,   0, 32'h0, 0));
    mrows.push_back(mk(0, 32'h0,   1, 0, 1, 1, 1, 32'h200, 0, 32'h0, 0));
    foreach (mrows[i]) apply(mrows[i], $sformatf("mis%0d", i));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
